program_loader: RTL and testbench

- Boot-time loader directly upstream of the CPU: accepts a framed byte stream and writes it into the 32x8 program memory before the core runs.
- Holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.
- Sits between an external byte source (testbench/UART front-end) and the memory write port plus CPU reset input.

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader_timer.sv | 29 ++
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared loader state encodings and image limits
package program_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LEN  = 3'd1,
        LDR_DATA = 3'd2,
        LDR_CHK  = 3'd3,
        LDR_DONE = 3'd4,
        LDR_ERR  = 3'd5
    } ldr_state_t;

    localparam int LDR_MEM_DEPTH = 32;

    function automatic logic is_loading(input ldr_state_t s);
        return (s == LDR_LEN) || (s == LDR_DATA) || (s == LDR_CHK);
    endfunction

endpackage

// File: rtl/program_loader_timer.sv
// rtl/program_loader_timer.sv - idle-cycle watchdog with terminal-count flag
module program_loader_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(LIMIT));

    // Saturates at LIMIT so the flag stays up until the owner reacts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed boot-image loader holding the CPU in reset until verified
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = LDR_MEM_DEPTH,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    ldr_state_t        state;
    ldr_state_t        state_next;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] len;
    logic [DATA_W-1:0] sum;
    logic              loading;
    logic              expired;
    logic              xfer;
    logic              last_byte;
    logic              bad_len;

    program_loader_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (loading),
        .clear   (xfer),
        .expired (expired)
    );

    assign loading   = is_loading(state);
    // A byte offered on the timeout cycle is refused rather than silently dropped.
    assign in_ready  = loading && !expired;
    assign xfer      = in_valid && in_ready;
    assign last_byte = (DATA_W'(count) == len - DATA_W'(1));
    assign bad_len   = (in_data == '0) || (in_data > DATA_W'(MEM_DEPTH));

    always_comb begin
        state_next = state;
        case (state)
            LDR_IDLE: begin
                if (start) state_next = LDR_LEN;
            end
            LDR_LEN: begin
                if (expired)   state_next = LDR_ERR;
                else if (xfer) state_next = bad_len ? LDR_ERR : LDR_DATA;
            end
            LDR_DATA: begin
                if (expired)                state_next = LDR_ERR;
                else if (xfer && last_byte) state_next = LDR_CHK;
            end
            LDR_CHK: begin
                if (expired)   state_next = LDR_ERR;
                else if (xfer) state_next = (in_data == sum) ? LDR_DONE : LDR_ERR;
            end
            LDR_DONE, LDR_ERR: begin
                if (start) state_next = LDR_LEN;
            end
            default: state_next = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LDR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status flags are registered from the next state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            cpu_rst <= 1'b1;
        end else begin
            busy    <= is_loading(state_next);
            done    <= (state_next == LDR_DONE);
            error   <= (state_next == LDR_ERR);
            cpu_rst <= (state_next != LDR_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            len      <= '0;
            sum      <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wr   <= 1'b0;
        end else begin
            mem_wr <= 1'b0;
            if (xfer && (state == LDR_LEN)) begin
                len   <= in_data;
                count <= '0;
                sum   <= '0;
            end
            if (xfer && (state == LDR_DATA)) begin
                mem_addr <= count;
                mem_data <= in_data;
                mem_wr   <= 1'b1;
                sum      <= sum + in_data;
                count    <= count + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wr;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    logic [4:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    typedef struct {
        logic [7:0] b[6];
        int         n;
        bit         exp_done;
        int         nwr;
    } vec_t;

    vec_t vecs[4];

    program_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wr   (mem_wr),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wr) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Caller sits at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin
            if (in_ready) ok = 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!ok) chk("handshake_timeout", 0, 1);
    endtask

    task automatic start_load(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_start_flags{busy,cpu_rst,done,error}"}, {busy, cpu_rst, done, error}, 4'b1100);
    endtask

    // Flags {busy,done,error,cpu_rst,in_ready} once the frame has ended.
    task automatic check_end(input string tag, input bit exp_done);
        @(negedge clk);
        if (exp_done) chk({tag, "_end_flags"}, {busy, done, error, cpu_rst, in_ready}, 5'b01000);
        else          chk({tag, "_end_flags"}, {busy, done, error, cpu_rst, in_ready}, 5'b00110);
    endtask

    task automatic check_write(input string tag, input int i, input logic [7:0] d);
        if (i < wr_addr_q.size()) begin
            chk($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], 32'(i));
            chk($sformatf("%s_wr%0d_data", tag, i), wr_data_q[i], d);
        end
    endtask

    initial begin
        logic [7:0] big[32];
        logic [7:0] bsum;
        bit         seen;

        vecs[0] = '{b: '{8'h03, 8'hA1, 8'h42, 8'h05, 8'hE7, 8'h00}, n: 5, exp_done: 0, nwr: 3};
        vecs[1] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, exp_done: 0, nwr: 0};
        vecs[2] = '{b: '{8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, exp_done: 0, nwr: 0};
        vecs[3] = '{b: '{8'h03, 8'hA1, 8'h42, 8'h05, 8'hE8, 8'h00}, n: 5, exp_done: 1, nwr: 3};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {in_ready, mem_addr, mem_data, mem_wr, cpu_rst, busy, done, error},
            {1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        for (int v = 0; v < 4; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            clear_writes();
            start_load(tag);
            for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].b[k], 0);
            check_end(tag, vecs[v].exp_done);
            chk({tag, "_nwr"}, wr_addr_q.size(), vecs[v].nwr);
            for (int i = 0; i < vecs[v].nwr; i++) check_write(tag, i, vecs[v].b[1 + i]);
        end

        // Reload after DONE with a one-byte image.
        clear_writes();
        start_load("reload");
        send_byte(8'h01, 0); send_byte(8'h7F, 0); send_byte(8'h7F, 0);
        check_end("reload", 1);
        chk("reload_nwr", wr_addr_q.size(), 1);
        check_write("reload", 0, 8'h7F);

        // Backpressure gaps below the timeout, plus a start pulse mid-load that must be ignored.
        clear_writes();
        start_load("bp");
        send_byte(8'h03, 10); send_byte(8'h11, 200);
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("bp_busy_after_start", {busy, in_ready}, 2'b11);
        send_byte(8'h22, 3); send_byte(8'h33, 250); send_byte(8'h66, 1);
        check_end("bp", 1);
        chk("bp_nwr", wr_addr_q.size(), 3);
        check_write("bp", 1, 8'h22);
        check_write("bp", 2, 8'h33);

        // Largest legal image.
        clear_writes();
        bsum = 8'h00;
        for (int i = 0; i < 32; i++) begin
            big[i] = 8'(i * 37 + 5);
            bsum   = bsum + big[i];
        end
        start_load("max");
        send_byte(8'h20, 0);
        for (int i = 0; i < 32; i++) send_byte(big[i], 0);
        send_byte(bsum, 0);
        check_end("max", 1);
        chk("max_nwr", wr_addr_q.size(), 32);
        check_write("max", 0, big[0]);
        check_write("max", 31, big[31]);

        // Idle gap mid-DATA: still loading at 254 idle cycles, error shortly after 255.
        clear_writes();
        start_load("to");
        send_byte(8'h03, 0); send_byte(8'hA1, 0); send_byte(8'h42, 0);
        repeat (254) @(negedge clk);
        chk("to_before_limit{busy,error}", {busy, error}, 2'b10);
        seen = 0;
        for (int t = 0; t < 6 && !seen; t++) begin
            @(negedge clk);
            if (error) seen = 1;
        end
        chk("to_error_seen", seen, 1);
        chk("to_flags{in_ready,done,cpu_rst}", {in_ready, done, cpu_rst}, 3'b001);
        chk("to_nwr", wr_addr_q.size(), 2);

        // Asynchronous reset mid-load, then a clean load.
        start_load("rst");
        send_byte(8'h03, 0); send_byte(8'hA1, 0); send_byte(8'h42, 0);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outputs", {in_ready, mem_addr, mem_data, mem_wr, cpu_rst, busy, done, error},
               {1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_writes();
        start_load("post_rst");
        send_byte(8'h03, 0); send_byte(8'hA1, 0); send_byte(8'h42, 0);
        send_byte(8'h05, 0); send_byte(8'hE8, 0);
        check_end("post_rst", 1);
        chk("post_rst_nwr", wr_addr_q.size(), 3);
        check_write("post_rst", 2, 8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
